// File: rtl/cross_pkg.sv
// Shared definitions for the crossbar control path: FSM states, width helpers
// and the default lane-slice geometry used by cross_ctrl and its requesters.
package cross_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    localparam int NUM_IN_DEF = 8;
    localparam int DW_IDX_DEF = 3;

    // Width of one full index vector (all lanes of one beat).
    function automatic int lane_w(input int num_in, input int dw_idx);
        return num_in * dw_idx;
    endfunction

    localparam int LANE_W = NUM_IN_DEF * DW_IDX_DEF;

    // Ceiling log2, floored at 1 so a select field never collapses to zero bits.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or
// after ptr, wrapping modulo NUM_REQ.
module rr_arbiter
    import cross_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      gnt_idx
);

    always_comb begin
        int   k;
        logic found;
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = PW'(k);
            end
        end
    end

endmodule

// File: rtl/cross_arb.sv
// Round-robin burst scheduler feeding one cross_ctrl crossbar: one beat per
// cycle, registered index bus, sideband aligned with the crossbar's ctrl stage.
module cross_arb
    import cross_pkg::*;
#(
    parameter  int NUM_IN    = NUM_IN_DEF,
    parameter  int DW_IDX    = DW_IDX_DEF,
    parameter  int NUM_REQ   = 4,
    parameter  int BURST_MAX = 16,
    localparam int LW        = lane_w(NUM_IN, DW_IDX),
    localparam int SW        = clog2(NUM_REQ),
    localparam int CW        = clog2(BURST_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*LW-1:0] req_idx,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [NUM_REQ-1:0]    cfg_en,
    output logic [LW-1:0]         xbar_idx,
    output logic                  out_valid,
    output logic [SW-1:0]         out_src,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err_idx
);

    state_e             state;
    logic [SW-1:0]      ptr;
    logic [SW-1:0]      owner;
    logic [CW-1:0]      bcnt;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [SW-1:0]      arb_idx;

    logic [SW-1:0]      sel;
    logic               accept;
    logic [LW-1:0]      sel_idx;
    logic               sel_last;
    logic               sel_bad;
    logic [SW-1:0]      ptr_after;
    logic [CW-1:0]      bcnt_next;
    logic               cap_hit;

    logic               s1_valid;
    logic [SW-1:0]      s1_src;
    logic               s1_last;

    assign elig = req_valid & cfg_en;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (elig),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // In IDLE the arbiter picks this cycle; in LOCK only the owner may move.
    always_comb begin
        req_ready = '0;
        sel       = owner;
        if (state == ST_IDLE) begin
            req_ready = arb_gnt;
            sel       = arb_idx;
        end else begin
            req_ready[owner] = elig[owner];
        end
    end

    assign accept   = |req_ready;
    assign sel_idx  = req_idx[sel*LW +: LW];
    assign sel_last = req_last[sel];

    always_comb begin
        sel_bad = 1'b0;
        for (int l = 0; l < NUM_IN; l++) begin
            if (int'(sel_idx[l*DW_IDX +: DW_IDX]) >= NUM_IN) sel_bad = 1'b1;
        end
    end

    assign ptr_after = (int'(sel) == NUM_REQ - 1) ? '0 : sel + SW'(1);
    // The first beat of a grant counts as beat one.
    assign bcnt_next = (state == ST_IDLE) ? CW'(1) : bcnt + CW'(1);
    assign cap_hit   = (bcnt_next == CW'(BURST_MAX));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
            bcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner <= sel;
                        bcnt  <= bcnt_next;
                        if (sel_last || cap_hit) ptr   <= ptr_after;
                        else                     state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (!cfg_en[owner]) begin
                        state <= ST_IDLE;
                        ptr   <= ptr_after;
                    end else if (accept) begin
                        bcnt <= bcnt_next;
                        if (sel_last || cap_hit) begin
                            state <= ST_IDLE;
                            ptr   <= ptr_after;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // xbar_idx only loads on accept so the crossbar select lines stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xbar_idx  <= '0;
            s1_valid  <= 1'b0;
            s1_src    <= '0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_src   <= '0;
            out_last  <= 1'b0;
            err_idx   <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                xbar_idx <= sel_idx;
                s1_src   <= sel;
                s1_last  <= sel_last;
                if (sel_bad) err_idx <= 1'b1;
            end
            out_valid <= s1_valid;
            out_src   <= s1_src;
            out_last  <= s1_last;
        end
    end

    assign busy = (state == ST_LOCK) || s1_valid;

endmodule

// File: tb/tb_cross_arb.sv
// Directed bench for cross_arb: stimulus pushes expected beats into a
// scoreboard that a negedge monitor drains against out_valid/out_src/out_last.
module tb_cross_arb;
    import cross_pkg::*;

    localparam int NR  = 4;
    localparam int NI  = 8;
    localparam int DW  = 3;
    localparam int LW  = NI * DW;
    localparam int BM  = 4;
    localparam int NI6 = 6;
    localparam int LW6 = NI6 * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NR-1:0]    req_valid, req_ready, req_last, cfg_en;
    logic [NR*LW-1:0] req_idx;
    logic [LW-1:0]    xbar_idx;
    logic             out_valid, out_last, busy, err_idx;
    logic [1:0]       out_src;

    logic [NR-1:0]     valid6, ready6, last6, en6;
    logic [NR*LW6-1:0] idx6;
    logic [LW6-1:0]    xbar6;
    logic              out_valid6, out_last6, busy6, err6;
    logic [1:0]        out_src6;

    cross_arb #(.NUM_IN(NI), .DW_IDX(DW), .NUM_REQ(NR), .BURST_MAX(BM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .req_last(req_last), .cfg_en(cfg_en), .xbar_idx(xbar_idx),
        .out_valid(out_valid), .out_src(out_src), .out_last(out_last),
        .busy(busy), .err_idx(err_idx)
    );

    cross_arb #(.NUM_IN(NI6), .DW_IDX(DW), .NUM_REQ(NR), .BURST_MAX(16)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid6), .req_ready(ready6), .req_idx(idx6),
        .req_last(last6), .cfg_en(en6), .xbar_idx(xbar6),
        .out_valid(out_valid6), .out_src(out_src6), .out_last(out_last6),
        .busy(busy6), .err_idx(err6)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   src;
        logic last;
        int   due;
    } beat_t;

    beat_t     sb[$];
    int        n_cmp = 0;
    int        n_bad = 0;
    int        nstep = 0;
    logic [LW-1:0] exp_xbar;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [LW-1:0] mk_idx(input int base);
        logic [LW-1:0] v;
        for (int l = 0; l < NI; l++) v[l*DW +: DW] = DW'((base + l) % NI);
        return v;
    endfunction

    // One cycle of stimulus; g is the hand-computed winner (-1 = no accept).
    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] l,
                        input logic [NR-1:0] e, input int g);
        logic [NR-1:0] er;
        beat_t         b;
        @(posedge clk);
        #1;
        req_valid = v;
        req_last  = l;
        cfg_en    = e;
        for (int r = 0; r < NR; r++) req_idx[r*LW +: LW] = mk_idx(r + nstep);
        nstep++;
        @(negedge clk);
        check("xbar_idx", xbar_idx, exp_xbar);
        er = (g < 0) ? '0 : NR'(1 << g);
        check("req_ready", req_ready, er);
        if (g >= 0) begin
            b.src  = g;
            b.last = l[g];
            b.due  = cyc + 2;
            sb.push_back(b);
            exp_xbar = req_idx[g*LW +: LW];
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '1, -1);
    endtask

    // Monitor: every out_valid beat must match the scoreboard head on time.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("out_unexpected", out_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("out_src", out_src, e.src);
                    check("out_last", out_last, e.last);
                    check("out_time", cyc, e.due);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                void'(sb.pop_front());
                check("out_missing", out_valid, 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0; req_last = '0; cfg_en = '1; req_idx = '0;
        valid6 = '0; last6 = '0; en6 = '1; idx6 = '0;
        exp_xbar = '0;

        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_src", out_src, 2'd0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_xbar_idx", xbar_idx, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_err_idx", err_idx, 1'b0);
        check("rst_req_ready", req_ready, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness: everyone valid with one-beat packets, ptr starts at 0.
        for (int i = 0; i < 8; i++) step(4'hF, 4'hF, 4'hF, i % NR);

        // Single requester, three beats, identity lanes on beat 1.
        step(4'b0001, 4'b0000, 4'hF, 0);
        step(4'b0001, 4'b0000, 4'hF, 0);
        check("xbar_beat1", xbar_idx, 24'hFAC688);
        check("busy_lock", busy, 1'b1);
        step(4'b0001, 4'b0001, 4'hF, 0);
        drain(3);
        check("busy_idle", busy, 1'b0);

        // Burst cap of 4: r1 streams 10 beats, r2 has one-beat packets.
        begin
            int g_seq [12] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1, 1};
            for (int i = 0; i < 12; i++)
                step(4'b0110, (i == 11) ? 4'b0110 : 4'b0100, 4'hF, g_seq[i]);
        end
        drain(2);

        // cfg_en drop while r0 holds the lock; r3 wins the next pick.
        step(4'b0001, 4'b0000, 4'hF, 0);
        step(4'b0001, 4'b0000, 4'hF, 0);
        step(4'b1001, 4'b0000, 4'b1110, -1);
        step(4'b1001, 4'b1000, 4'b1110, 3);
        drain(3);

        // Reset while r2 holds the lock with two beats in the pipe.
        step(4'b0100, 4'b0000, 4'hF, 2);
        step(4'b0100, 4'b0000, 4'hF, 2);
        @(posedge clk);
        #2;
        check("busy_before_rst", busy, 1'b1);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_src", out_src, 2'd0);
        check("mid_rst_xbar_idx", xbar_idx, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_req_ready", req_ready, 4'b0000);
        sb.delete();
        exp_xbar = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'hF, 4'hF, 4'hF, 0);
        drain(3);
        check("post_rst_busy", busy, 1'b0);

        // Out-of-range lane index on the six-lane instance.
        @(posedge clk); #1;
        valid6 = 4'b0001; last6 = 4'b0001; idx6[LW6-1:0] = 18'h2C688;
        @(negedge clk);
        check("bad_ready_good", ready6, 4'b0001);
        check("bad_err_clear", err6, 1'b0);
        @(posedge clk); #1;
        idx6[LW6-1:0] = 18'h2C7C8;
        @(negedge clk);
        check("bad_ready_bad", ready6, 4'b0001);
        check("bad_err_good_beat", err6, 1'b0);
        check("bad_xbar_good", xbar6, 18'h2C688);
        @(posedge clk); #1;
        valid6 = '0;
        @(negedge clk);
        check("bad_err_rise", err6, 1'b1);
        check("bad_xbar_bad", xbar6, 18'h2C7C8);
        check("bad_out_good", out_valid6, 1'b1);
        @(negedge clk);
        check("bad_out_valid", out_valid6, 1'b1);
        check("bad_out_src", out_src6, 2'd0);
        check("bad_out_last", out_last6, 1'b1);
        check("bad_err_hold", err6, 1'b1);
        @(negedge clk);
        check("bad_out_done", out_valid6, 1'b0);
        check("bad_err_sticky", err6, 1'b1);

        check("main_err_idx", err_idx, 1'b0);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
